// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   NUM_CH independent programmable down-counters used as the shared timing
//   source for game logic (movement rates, ghost mode timers, frightened
//   timeout, frame pacing). Each channel has a run-time reload register,
//   start/stop control, periodic or one-shot mode and a registered
//   terminal-count tick.
//
// Ports
//   CLOCK_50  system clock, all state updates on the rising edge
//   reset     asynchronous, active-low reset
//   load      per-channel strobe: write load_val into reload and counter
//   load_val  reload value shared by all channels
//   start     per-channel strobe: (re)start channel from its reload value
//   stop      per-channel strobe: halt channel, counter holds (stop wins)
//   oneshot   mode sampled on start: 1 = one-shot, 0 = periodic
//   count     current counter values, channel i at [i*WIDTH +: WIDTH]
//   running   channel i is counting
//   tick      one-cycle registered pulse per terminal count
//   tick_any  combinational OR of tick
// -----------------------------------------------------------------------------
module multi_timer #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_MAX = 50000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       load,
  input  logic [WIDTH-1:0]        load_val,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       oneshot,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       tick,
  output logic                    tick_any
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_MAX);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] cnt;
    logic             run;
    logic             mode;     // 1 = one-shot, 0 = periodic
    logic             tk;

    logic [WIDTH-1:0] reload_next;
    logic [WIDTH-1:0] cnt_next;
    logic             run_next;
    logic             mode_next;
    logic             tk_next;

    // Priority: load rewrites the counter, stop beats start, and the
    // countdown only advances on cycles with no strobe at all.
    always_comb begin
      reload_next = reload;
      cnt_next    = cnt;
      run_next    = run;
      mode_next   = mode;
      tk_next     = 1'b0;

      if (load[i]) begin
        reload_next = load_val;
        cnt_next    = load_val;
      end

      if (stop[i]) begin
        run_next = 1'b0;
      end else if (start[i]) begin
        run_next  = 1'b1;
        mode_next = oneshot[i];
        cnt_next  = load[i] ? load_val : reload;
      end else if (!load[i] && run) begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (!mode) begin
          tk_next  = 1'b1;
          cnt_next = reload;
        end else begin
          // One-shot terminal count: halt with the counter parked at zero.
          tk_next  = 1'b1;
          run_next = 1'b0;
        end
      end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
        reload <= RESET_VAL;
        cnt    <= RESET_VAL;
        run    <= 1'b0;
        mode   <= 1'b0;
        tk     <= 1'b0;
      end else begin
        reload <= reload_next;
        cnt    <= cnt_next;
        run    <= run_next;
        mode   <= mode_next;
        tk     <= tk_next;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt;
    assign running[i]              = run;
    assign tick[i]                 = tk;
  end

  assign tick_any = |tick;

endmodule

// File: tb/tb_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_timer
//   Directed, table-driven bench for multi_timer with NUM_CH=2, WIDTH=4,
//   DEFAULT_MAX=10. Each table row holds the strobes applied for one clock
//   edge and the hand-computed outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_multi_timer;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 4;
  localparam int DMAX   = 10;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       load;
  logic [WIDTH-1:0]        load_val;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       oneshot;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH-1:0]       tick;
  logic                    tick_any;

  multi_timer #(
    .NUM_CH     (NUM_CH),
    .WIDTH      (WIDTH),
    .DEFAULT_MAX(DMAX)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .stop    (stop),
    .oneshot (oneshot),
    .count   (count),
    .running (running),
    .tick    (tick),
    .tick_any(tick_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ld;
    logic [3:0] lv;
    logic [1:0] st;
    logic [1:0] sp;
    logic [1:0] os;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [1:0] run;
    logic [1:0] tk;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic [1:0] ld, input logic [3:0] lv,
                              input logic [1:0] st, input logic [1:0] sp,
                              input logic [1:0] os, input logic [3:0] c0,
                              input logic [3:0] c1, input logic [1:0] run,
                              input logic [1:0] tk);
    vec_t v;
    v = '{ld, lv, st, sp, os, c0, c1, run, tk};
    vq.push_back(v);
  endfunction

  function automatic void idle(input logic [3:0] c0, input logic [3:0] c1,
                               input logic [1:0] run, input logic [1:0] tk);
    add(2'b00, 4'd0, 2'b00, 2'b00, 2'b00, c0, c1, run, tk);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [1:0] run, input logic [1:0] tk);
    chk({tag, " count"},    32'(count),    32'({c1, c0}));
    chk({tag, " running"},  32'(running),  32'(run));
    chk({tag, " tick"},     32'(tick),     32'(tk));
    chk({tag, " tick_any"}, 32'(tick_any), 32'(|tk));
  endtask

  task automatic clear_inputs();
    load     = '0;
    load_val = '0;
    start    = '0;
    stop     = '0;
    oneshot  = '0;
  endtask

  initial begin
    // Periodic ch0 from reset value 10: period of 11 cycles.
    add(2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 4'd10, 4'd10, 2'b01, 2'b00);
    for (int k = 9; k >= 0; k--) idle(4'(k), 4'd10, 2'b01, 2'b00);
    idle(4'd10, 4'd10, 2'b01, 2'b01);
    for (int k = 9; k >= 0; k--) idle(4'(k), 4'd10, 2'b01, 2'b00);
    idle(4'd10, 4'd10, 2'b01, 2'b01);
    for (int k = 9; k >= 6; k--) idle(4'(k), 4'd10, 2'b01, 2'b00);
    // Stop ch0 at 6: counter holds.
    add(2'b00, 4'd0, 2'b00, 2'b01, 2'b00, 4'd6, 4'd10, 2'b00, 2'b00);
    idle(4'd6, 4'd10, 2'b00, 2'b00);
    idle(4'd6, 4'd10, 2'b00, 2'b00);
    // One-shot ch1 loaded with 3.
    add(2'b10, 4'd3, 2'b10, 2'b00, 2'b10, 4'd6, 4'd3, 2'b10, 2'b00);
    idle(4'd6, 4'd2, 2'b10, 2'b00);
    idle(4'd6, 4'd1, 2'b10, 2'b00);
    idle(4'd6, 4'd0, 2'b10, 2'b00);
    idle(4'd6, 4'd0, 2'b00, 2'b10);
    idle(4'd6, 4'd0, 2'b00, 2'b00);
    idle(4'd6, 4'd0, 2'b00, 2'b00);
    // Restart ch0 from its reload value.
    add(2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 4'd10, 4'd0, 2'b01, 2'b00);
    idle(4'd9, 4'd0, 2'b01, 2'b00);
    idle(4'd8, 4'd0, 2'b01, 2'b00);
    // Load 0 into running ch0: rewrite, no decrement, no tick.
    add(2'b01, 4'd0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00);
    // Start with reload 0 periodic: tick every cycle, count stays 0.
    add(2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00);
    idle(4'd0, 4'd0, 2'b01, 2'b01);
    idle(4'd0, 4'd0, 2'b01, 2'b01);
    idle(4'd0, 4'd0, 2'b01, 2'b01);
    // Start and stop together: stop wins, no tick.
    add(2'b00, 4'd0, 2'b01, 2'b01, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);
    idle(4'd0, 4'd0, 2'b00, 2'b00);
    idle(4'd0, 4'd0, 2'b00, 2'b00);
    // Set up ch0=5, ch1=2 before the asynchronous reset.
    add(2'b10, 4'd3, 2'b10, 2'b00, 2'b00, 4'd0, 4'd3, 2'b10, 2'b00);
    add(2'b01, 4'd5, 2'b01, 2'b00, 2'b00, 4'd5, 4'd2, 2'b11, 2'b00);

    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'd10, 4'd10, 2'b00, 2'b00);
    reset = 1'b1;

    for (int n = 0; n < vq.size(); n++) begin
      load     = vq[n].ld;
      load_val = vq[n].lv;
      start    = vq[n].st;
      stop     = vq[n].sp;
      oneshot  = vq[n].os;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", n), vq[n].c0, vq[n].c1, vq[n].run, vq[n].tk);
    end
    clear_inputs();

    // Asynchronous reset between edges with ch0=5, ch1=2.
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 4'd10, 4'd10, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset clears a tick that is currently high.
    load     = 2'b01;
    load_val = 4'd0;
    start    = 2'b01;
    @(posedge clk);
    #1;
    clear_inputs();
    chk_all("inflight_start", 4'd0, 4'd10, 2'b01, 2'b00);
    @(posedge clk);
    #1;
    chk_all("inflight_tick", 4'd0, 4'd10, 2'b01, 2'b01);
    #2;
    reset = 1'b0;
    #1;
    chk_all("inflight_reset", 4'd10, 4'd10, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised, multi-channel successor to the single free-running down counter.
- Provides NUM_CH independent programmable down-counters. Each channel has a run-time reload value, start/stop control, periodic or one-shot mode, and a registered terminal-count tick.
- Serves as the shared timing source for game logic: movement rates, ghost mode timers, frightened timeout and frame pacing.

Parameters:
NUM_CH, 4, number of independent timer channels
WIDTH, 26, bit width of each channel's counter and reload register
DEFAULT_MAX, 50000000, reset value of every reload register and counter; must be < 2**WIDTH

Ports:
CLOCK_50  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
load  in  NUM_CH  per-channel strobe: write load_val into reload register and counter
load_val  in  WIDTH  reload value shared by all channels, used by any channel with load set
start  in  NUM_CH  per-channel strobe: (re)start channel from its reload value
stop  in  NUM_CH  per-channel strobe: halt channel, counter holds
oneshot  in  NUM_CH  mode sampled on start: 1 = one-shot, 0 = periodic
count  out  NUM_CH*WIDTH  current counter values, channel i at [i*WIDTH +: WIDTH]
running  out  NUM_CH  channel i is counting
tick  out  NUM_CH  one-cycle registered pulse per terminal count
tick_any  out  1  combinational OR of tick

Behaviour:
- Reset (reset low, asynchronous, no clock needed):
  - All reload and count registers go to DEFAULT_MAX.
  - running=0, mode=periodic, tick=0.
  - On release, the first rising edge with reset high is a normal cycle.
- Per-channel state: reload[i], cnt[i], run[i], mode[i], tick[i]. Channels are fully independent.
- Per-edge update for channel i, in this order:
  - tick[i] defaults to 0 every cycle unless set below.
  - If load[i]: reload[i]<=load_val and cnt[i]<=load_val. run/mode are unaffected unless start/stop are also asserted.
  - If stop[i]: run[i]<=0, cnt[i] holds (or takes load_val if load is also set). Stop beats start in the same cycle.
  - Else if start[i]: run[i]<=1, mode[i]<=oneshot[i], cnt[i]<=effective reload. Effective reload is load_val if load[i] is set, else reload[i]. Starting a running channel restarts it; no tick is produced.
  - Else if no load[i] and run[i]:
    - cnt[i]!=0: cnt[i]<=cnt[i]-1.
    - cnt[i]==0 and mode periodic: tick[i]<=1, cnt[i]<=reload[i].
    - cnt[i]==0 and mode one-shot: tick[i]<=1, run[i]<=0, cnt[i] holds at 0.
  - If load[i] is asserted on a running channel without start/stop: the counter is rewritten, no decrement that cycle, no tick.
- Timing:
  - Periodic period = reload+1 cycles.
  - tick is high during the cycle after count showed 0. In periodic mode, count shows reload in that same cycle.
  - Latency from start edge to first tick = reload+1 cycles.
- Boundary conditions:
  - reload=0 periodic: tick high every cycle while running, count stays 0.
  - reload=0 one-shot: single tick one cycle after start.
  - Stopped channels never tick and never change count except via load.
  - Counter arithmetic is unsigned WIDTH bits; no underflow is possible because 0 always reloads or halts.
- Reset mid-operation aborts all channels immediately. Any tick in flight is cleared.

Test Plan:
All scenarios use NUM_CH=2, WIDTH=4, DEFAULT_MAX=10.
1. Hold reset low 2 cycles, release -> count={10,10}, running=00, tick=00, tick_any=0.
2. start[0] pulse, oneshot[0]=0 -> ch0 count 10,9,...,0. Next cycle tick[0]=1 with count0=10, then repeats every 11 cycles. ch1 stays at 10.
3. load[1]+start[1] with load_val=3, oneshot[1]=1 -> count1 3,2,1,0. One tick[1] pulse, running[1]=0, count1 holds 0, no further ticks.
4. ch0 running periodic, stop[0] when count0=6 -> count0 holds 6, running[0]=0. A later start[0] -> count0=10, counting resumes.
5. load[0] with load_val=0, then start[0] periodic -> tick[0]=1 every cycle. Simultaneous start[0]+stop[0] -> channel stopped, no tick.
6. Drive reset low between clock edges while ch0=5 and ch1=2 -> count={10,10}, running=00, tick=00 immediately, before the next edge.
